decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32IMF decode stage sitting between fetch and execute. It turns each 32-bit instruction into the core control bundle, including F-extension opcodes, an illegal-instruction flag and extension gating. It moves instructions with valid/ready handshakes on both sides and supports a flush. It also tracks busy windows of the multi-cycle MUL and FPU units, so a dependent long-op is never issued while its unit is occupied.

## Interface
- XLEN, 32: PC width carried through the stage.
- ENABLE_M, 1: 0 makes OP with funct7=0000001 illegal.
- ENABLE_F, 1: 0 makes all FP opcodes illegal.
- MUL_LAT, 3: MUL unit occupancy in cycles, ≥1.
- FPU_LAT, 4: FPU occupancy in cycles for OP-FP/FMA, ≥1.
- clk  in  1  clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the stage contents.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  registered PC.
- out_instr  out  32  registered instruction, for immediate and register fields downstream.
- out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_mul_en, out_fpu_en, out_fp_dest, out_illegal  out  1 each  control bits.
- out_jump  out  2  10=JAL, 01=JALR, 00=none.
- out_alu_op  out  2  00=add, 01=branch compare, 10=funct-decoded, 11=upper-immediate.

## Operation
Decode per opcode. Listed bits are 1; all others are 0 and alu_op=00.
- OP, funct7≠0000001: reg_write, alu_op=10.
- OP, funct7=0000001: mul_en, reg_write. Illegal if !ENABLE_M.
- OP-IMM 0010011: alu_src, reg_write, alu_op=10.
- LOAD 0000011: mem_read, mem_to_reg, alu_src, reg_write.
- STORE 0100011: mem_write, alu_src.
- BRANCH 1100011: branch, alu_op=01.
- JAL 1101111: reg_write, jump=10.
- JALR 1100111: alu_src, reg_write, jump=01.
- LUI 0110111 and AUIPC 0010111: alu_src, reg_write, alu_op=11.
- LOAD-FP 0000111: mem_read, mem_to_reg, alu_src, reg_write, fp_dest.
- STORE-FP 0100111: mem_write, alu_src.
- OP-FP 1010011 and FMADD/FMSUB/FNMSUB/FNMADD (1000011/1000111/1001011/1001111): fpu_en, reg_write, fp_dest.
- Any FP opcode with !ENABLE_F, or any other opcode: illegal=1, every other bit 0.
- Illegal instructions still flow through the pipe so execute can trap.

Long ops are mul_en or fpu_en. Each unit has a busy counter (mul_cnt, fpu_cnt):
- On issue of that unit's op (out_valid && out_ready), the counter loads LAT-1.
- Otherwise it decrements while nonzero.

Acceptance:
- in_ready = !flush && (!out_valid || out_ready) && !hold.
- hold=1 when the incoming instruction is a MUL op and either mul_cnt≠0, or the register holds a MUL op (issued or not). FPU uses the same rule with fpu_cnt.

## Timing
- Reset: out_valid=0, out_* bundle all 0, out_pc=0, out_instr=0, mul_cnt=fpu_cnt=0. in_ready goes to 1 the cycle after reset release.
- Latency: 1 cycle from accept to out_valid.
- Full throughput: back-to-back non-long ops, one per cycle, while out_ready=1.
- Once out_valid=1, the bundle is stable until out_ready=1 or flush.
- Flush: out_valid=0 next cycle and in_ready=0 in the flush cycle. Counters are not cleared, because units are still in flight.
- Simultaneous flush and out_ready: no issue is counted and no counter load occurs.
- Simultaneous issue and accept: the register is replaced by the new instruction in the same edge.
- LAT=1: counter loads 0. The next same-unit op is accepted the cycle after issue.
- Reset mid-operation discards the bundle and counters immediately.

## Structure
- Package rv_decode_pkg holds:
  - opcode localparams;
  - jump and alu_op encodings;
  - packed struct ctrl_t for the bundle.
- Combinational sub-module ctrl_decode (instr, ENABLE_M/F → ctrl_t).
- decode_stage contains the pipeline register, handshake and busy counters.

## Test plan
- After reset, issue ADD 0x00B50533 with out_ready=1 → out_valid next cycle, reg_write=1, alu_op=10, all other bits 0.
- MUL 0x02B50533 then MUL back-to-back, MUL_LAT=3, out_ready=1:
  - first issues at cycle t;
  - in_ready=0 from accept through t+2;
  - second is accepted at t+3.
- FLW 0x0005A507 → mem_read, mem_to_reg, alu_src, reg_write, fp_dest=1, fpu_en=0, with no FPU stall.
- ENABLE_F=0, FADD.S 0x00B57553 → illegal=1, all other bits 0.
- Hold out_ready=0 for 5 cycles with a LW pending → bundle stable and in_ready=0. Release → issue, then the next instruction is accepted.
- Assert flush with out_valid=1 → out_valid=0 next cycle, no issue counted. Assert rst_n low mid-stall → all outputs 0 asynchronously.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared types and encodings for the RV32IMF decode stage.
// Opcode constants, jump/alu_op encodings and the packed control bundle.
// Pure declarations; no timing or backpressure of its own.
package rv_decode_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

  // funct7 value that selects the M extension inside the OP opcode
  localparam logic [6:0] F7_MULDIV    = 7'b0000001;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JALR = 2'b01,
    JMP_JAL  = 2'b10
  } jump_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_UPPER  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    branch;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    mul_en;
    logic    fpu_en;
    logic    fp_dest;
    logic    illegal;
    jump_e   jump;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the control bundle.
// Zero latency (pure combinational).
// No backpressure; the caller decides when the result is captured.
module ctrl_decode
  import rv_decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_F = 1'b1
) (
  input  logic [6:0] i_opcode,
  input  logic [6:0] i_funct7,
  output ctrl_t      o_ctrl
);

  // Map opcode to control bits; anything unrecognised or disabled is illegal with all other bits clear
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OPC_OP: begin
        if (i_funct7 == F7_MULDIV) begin
          if (ENABLE_M) begin
            o_ctrl.mul_en    = 1'b1;
            o_ctrl.reg_write = 1'b1;
          end else begin
            o_ctrl.illegal   = 1'b1;
          end
        end else begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALU_FUNCT;
        end
      end
      OPC_OP_IMM: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      OPC_LOAD: begin
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      OPC_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_BRANCH;
      end
      OPC_JAL: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = JMP_JAL;
      end
      OPC_JALR: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = JMP_JALR;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_UPPER;
      end
      OPC_LOAD_FP: begin
        if (ENABLE_F) begin
          o_ctrl.mem_read   = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.alu_src    = 1'b1;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.fp_dest    = 1'b1;
        end else begin
          o_ctrl.illegal    = 1'b1;
        end
      end
      OPC_STORE_FP: begin
        if (ENABLE_F) begin
          o_ctrl.mem_write = 1'b1;
          o_ctrl.alu_src   = 1'b1;
        end else begin
          o_ctrl.illegal   = 1'b1;
        end
      end
      OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        if (ENABLE_F) begin
          o_ctrl.fpu_en    = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.fp_dest   = 1'b1;
        end else begin
          o_ctrl.illegal   = 1'b1;
        end
      end
      default: begin
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute, with MUL/FPU busy tracking.
// Latency: 1 cycle from accept to out_valid; full throughput for non-long ops.
// Backpressure: in_ready drops on flush, a stalled output, or a long op whose unit is busy.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_F = 1'b1,
  parameter int MUL_LAT  = 3,
  parameter int FPU_LAT  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_branch,
  output logic            out_mem_read,
  output logic            out_mem_to_reg,
  output logic            out_mem_write,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_mul_en,
  output logic            out_fpu_en,
  output logic            out_fp_dest,
  output logic            out_illegal,
  output logic [1:0]      out_jump,
  output logic [1:0]      out_alu_op
);

  // Counters only need to hold LAT-1; keep at least one bit for LAT=1
  localparam int MUL_CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int FPU_CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  ctrl_t             w_in_ctrl;
  ctrl_t             r_ctrl;
  logic              r_vld;
  logic              r_init;
  logic [XLEN-1:0]   r_pc;
  logic [31:0]       r_instr;
  logic [MUL_CW-1:0] r_mul_cnt;
  logic [FPU_CW-1:0] r_fpu_cnt;
  logic              w_issue;
  logic              w_accept;
  logic              w_hold_mul;
  logic              w_hold_fpu;

  ctrl_decode #(
    .ENABLE_M (ENABLE_M),
    .ENABLE_F (ENABLE_F)
  ) u_ctrl_decode (
    .i_opcode (in_instr[6:0]),
    .i_funct7 (in_instr[31:25]),
    .o_ctrl   (w_in_ctrl)
  );

  // A long op waits while its unit is counting down or while the register
  // still holds an op for the same unit (it either has not left yet or is
  // leaving this cycle and will reload the counter).
  assign w_hold_mul = w_in_ctrl.mul_en && ((r_mul_cnt != '0) || (r_vld && r_ctrl.mul_en));
  assign w_hold_fpu = w_in_ctrl.fpu_en && ((r_fpu_cnt != '0) || (r_vld && r_ctrl.fpu_en));

  // A flush wins over a simultaneous out_ready, so it never counts as an issue
  assign w_issue  = r_vld && out_ready && !flush;
  assign in_ready = r_init && !flush && (!r_vld || out_ready) && !w_hold_mul && !w_hold_fpu;
  assign w_accept = in_valid && in_ready;

  // Hold in_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  // Pipeline register: flush kills, accept replaces (also on issue), otherwise drain on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (flush) begin
      r_vld   <= 1'b0;
    end else if (w_accept) begin
      r_vld   <= 1'b1;
      r_ctrl  <= w_in_ctrl;
      r_pc    <= in_pc;
      r_instr <= in_instr;
    end else if (out_ready) begin
      r_vld   <= 1'b0;
    end
  end

  // MUL busy window: load on issue, otherwise count down to zero; flush leaves it running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_mul_cnt <= '0;
    else if (w_issue && r_ctrl.mul_en)   r_mul_cnt <= MUL_CW'(MUL_LAT - 1);
    else if (r_mul_cnt != '0)            r_mul_cnt <= r_mul_cnt - MUL_CW'(1);
  end

  // FPU busy window: same scheme as the MUL counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_fpu_cnt <= '0;
    else if (w_issue && r_ctrl.fpu_en)   r_fpu_cnt <= FPU_CW'(FPU_LAT - 1);
    else if (r_fpu_cnt != '0)            r_fpu_cnt <= r_fpu_cnt - FPU_CW'(1);
  end

  assign out_valid      = r_vld;
  assign out_pc         = r_pc;
  assign out_instr      = r_instr;
  assign out_branch     = r_ctrl.branch;
  assign out_mem_read   = r_ctrl.mem_read;
  assign out_mem_to_reg = r_ctrl.mem_to_reg;
  assign out_mem_write  = r_ctrl.mem_write;
  assign out_alu_src    = r_ctrl.alu_src;
  assign out_reg_write  = r_ctrl.reg_write;
  assign out_mul_en     = r_ctrl.mul_en;
  assign out_fpu_en     = r_ctrl.fpu_en;
  assign out_fp_dest    = r_ctrl.fp_dest;
  assign out_illegal    = r_ctrl.illegal;
  assign out_jump       = r_ctrl.jump;
  assign out_alu_op     = r_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: instance A uses the default parameters,
// instance B has ENABLE_F=0 and MUL_LAT=1. Bundles are compared as a 14-bit
// vector {branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,mul_en,fpu_en,fp_dest,illegal,jump,alu_op}.
module tb_decode_stage;

  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_MUL  = 32'h02B50533;
  localparam logic [31:0] I_FLW  = 32'h0005A507;
  localparam logic [31:0] I_FADD = 32'h00B57553;
  localparam logic [31:0] I_LW   = 32'h0005A503;
  localparam logic [31:0] I_BEQ  = 32'h00B50463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;

  localparam logic [13:0] B_ADD  = 14'h0102;
  localparam logic [13:0] B_MUL  = 14'h0180;
  localparam logic [13:0] B_FLW  = 14'h1B20;
  localparam logic [13:0] B_FADD = 14'h0160;
  localparam logic [13:0] B_LW   = 14'h1B00;
  localparam logic [13:0] B_ILL  = 14'h0010;
  localparam logic [13:0] B_BEQ  = 14'h2001;
  localparam logic [13:0] B_JAL  = 14'h0108;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_instr = '0, a_in_pc = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_out_instr;
  logic        a_branch, a_mem_read, a_mem_to_reg, a_mem_write, a_alu_src;
  logic        a_reg_write, a_mul_en, a_fpu_en, a_fp_dest, a_illegal;
  logic [1:0]  a_jump, a_alu_op;
  logic [13:0] a_bun;
  assign a_bun = {a_branch, a_mem_read, a_mem_to_reg, a_mem_write, a_alu_src,
                  a_reg_write, a_mul_en, a_fpu_en, a_fp_dest, a_illegal, a_jump, a_alu_op};

  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_in_instr = '0, b_in_pc = '0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_pc, b_out_instr;
  logic        b_branch, b_mem_read, b_mem_to_reg, b_mem_write, b_alu_src;
  logic        b_reg_write, b_mul_en, b_fpu_en, b_fp_dest, b_illegal;
  logic [1:0]  b_jump, b_alu_op;
  logic [13:0] b_bun;
  assign b_bun = {b_branch, b_mem_read, b_mem_to_reg, b_mem_write, b_alu_src,
                  b_reg_write, b_mul_en, b_fpu_en, b_fp_dest, b_illegal, b_jump, b_alu_op};

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_F(1'b1), .MUL_LAT(3), .FPU_LAT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
    .out_branch(a_branch), .out_mem_read(a_mem_read), .out_mem_to_reg(a_mem_to_reg),
    .out_mem_write(a_mem_write), .out_alu_src(a_alu_src), .out_reg_write(a_reg_write),
    .out_mul_en(a_mul_en), .out_fpu_en(a_fpu_en), .out_fp_dest(a_fp_dest),
    .out_illegal(a_illegal), .out_jump(a_jump), .out_alu_op(a_alu_op)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_F(1'b0), .MUL_LAT(1), .FPU_LAT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .out_branch(b_branch), .out_mem_read(b_mem_read), .out_mem_to_reg(b_mem_to_reg),
    .out_mem_write(b_mem_write), .out_alu_src(b_alu_src), .out_reg_write(b_reg_write),
    .out_mul_en(b_mul_en), .out_fpu_en(b_fpu_en), .out_fp_dest(b_fp_dest),
    .out_illegal(b_illegal), .out_jump(b_jump), .out_alu_op(b_alu_op)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Count negedges spent with in_ready low on instance A, bounded
  task automatic a_wait_ready(output int n);
    n = 0;
    while (!a_in_ready && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    #12;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_bundle",    a_bun,       14'h0);
    chk("rst_out_pc",    a_out_pc,    32'h0);
    chk("rst_out_instr", a_out_instr, 32'h0);
    chk("rst_in_ready",  a_in_ready,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", a_in_ready, 1'b0);

    // ADD: one-cycle latency, then issue
    @(negedge clk);
    a_in_valid = 1'b1; a_in_instr = I_ADD; a_in_pc = 32'h100; a_out_ready = 1'b1;
    #1 chk("add_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    chk("add_out_valid", a_out_valid, 1'b1);
    chk("add_bundle",    a_bun,       B_ADD);
    chk("add_out_pc",    a_out_pc,    32'h100);
    chk("add_out_instr", a_out_instr, I_ADD);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("add_drained", a_out_valid, 1'b0);

    // MUL back-to-back with MUL_LAT=3
    a_in_valid = 1'b1; a_in_instr = I_MUL; a_in_pc = 32'h104;
    #1 chk("mul1_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    chk("mul1_bundle", a_bun, B_MUL);
    a_in_pc = 32'h108;
    #1 chk("mul2_held", a_in_ready, 1'b0);
    a_wait_ready(n);
    chk("mul2_wait_cycles", n, 3);
    @(negedge clk);
    chk("mul2_out_valid", a_out_valid, 1'b1);
    chk("mul2_out_pc",    a_out_pc,    32'h108);
    a_in_valid = 1'b0;

    // FADD then FLW: FLW is not held by FPU activity; a second FADD waits FPU_LAT-1 cycles
    @(negedge clk);
    a_in_valid = 1'b1; a_in_instr = I_FADD; a_in_pc = 32'h10C;
    #1 chk("fadd_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    chk("fadd_bundle", a_bun, B_FADD);
    a_in_instr = I_FLW; a_in_pc = 32'h110;
    #1 chk("flw_no_stall", a_in_ready, 1'b1);
    @(negedge clk);
    chk("flw_bundle", a_bun,    B_FLW);
    chk("flw_out_pc", a_out_pc, 32'h110);
    a_in_instr = I_FADD; a_in_pc = 32'h114;
    #1 chk("fadd2_held", a_in_ready, 1'b0);
    a_wait_ready(n);
    chk("fadd2_wait_cycles", n, 3);
    @(negedge clk);
    chk("fadd2_out_pc", a_out_pc, 32'h114);
    a_in_valid = 1'b0;

    // LW stalled by out_ready=0 for 5 cycles
    @(negedge clk);
    a_in_valid = 1'b1; a_in_instr = I_LW; a_in_pc = 32'h200; a_out_ready = 1'b0;
    #1 chk("lw_in_ready", a_in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", a_out_valid, 1'b1);
      chk("stall_bundle",    a_bun,       B_LW);
      chk("stall_out_pc",    a_out_pc,    32'h200);
      a_in_instr = I_ADD; a_in_pc = 32'h204;
      #1 chk("stall_in_ready", a_in_ready, 1'b0);
    end
    @(negedge clk);
    a_out_ready = 1'b1;
    #1 chk("release_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    chk("replace_out_valid", a_out_valid, 1'b1);
    chk("replace_out_pc",    a_out_pc,    32'h204);
    chk("replace_bundle",    a_bun,       B_ADD);
    a_in_valid = 1'b0;

    // Flush with out_ready high: no issue, MUL counter stays idle
    @(negedge clk);
    a_in_valid = 1'b1; a_in_instr = I_MUL; a_in_pc = 32'h300;
    #1 chk("fl_mul_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    chk("fl_out_valid_pre", a_out_valid, 1'b1);
    a_in_valid = 1'b0; a_flush = 1'b1;
    #1 chk("fl_in_ready", a_in_ready, 1'b0);
    @(negedge clk);
    chk("fl_out_valid_post", a_out_valid, 1'b0);
    a_flush = 1'b0;
    a_in_valid = 1'b1; a_in_pc = 32'h304;
    #1 chk("fl_no_cnt_load", a_in_ready, 1'b1);
    @(negedge clk);
    chk("fl_mul2_out_pc", a_out_pc, 32'h304);
    a_in_valid = 1'b0; a_out_ready = 1'b0;

    // Asynchronous reset in the middle of a stall
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", a_out_valid, 1'b0);
    chk("arst_bundle",    a_bun,       14'h0);
    chk("arst_out_pc",    a_out_pc,    32'h0);
    chk("arst_out_instr", a_out_instr, 32'h0);
    chk("arst_in_ready",  a_in_ready,  1'b0);
    @(negedge clk);
    rst_n = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_instr = I_MUL; a_in_pc = 32'h400;
    #1 chk("arst_mul_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    a_in_valid = 1'b0;

    // Instance B: FP disabled, MUL_LAT=1, plus branch/jump decode
    b_in_valid = 1'b1; b_in_instr = I_FADD; b_in_pc = 32'h500; b_out_ready = 1'b1;
    #1 chk("b_fadd_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    chk("b_fadd_out_valid", b_out_valid, 1'b1);
    chk("b_fadd_illegal",   b_bun,       B_ILL);
    b_in_instr = I_FLW; b_in_pc = 32'h504;
    @(negedge clk);
    chk("b_flw_illegal", b_bun, B_ILL);
    b_in_instr = I_BEQ; b_in_pc = 32'h508;
    @(negedge clk);
    chk("b_beq_bundle", b_bun, B_BEQ);
    b_in_instr = I_JAL; b_in_pc = 32'h50C;
    @(negedge clk);
    chk("b_jal_bundle", b_bun, B_JAL);
    b_in_instr = I_MUL; b_in_pc = 32'h510;
    @(negedge clk);
    chk("b_mul_bundle", b_bun, B_MUL);
    b_in_pc = 32'h514;
    #1 chk("b_mul2_held", b_in_ready, 1'b0);
    @(negedge clk);
    chk("b_mul_issued", b_out_valid, 1'b0);
    #1 chk("b_lat1_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    chk("b_mul2_out_valid", b_out_valid, 1'b1);
    chk("b_mul2_out_pc",    b_out_pc,    32'h514);
    b_in_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
